// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_pkg
//  Description : Shared text-mode geometry, control codes and writer FSM
//                encoding. Also used by the display side to decode the
//                {row, col} screen RAM address.
//  Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

    // Screen geometry defaults and fill code
    localparam int          TEXT_COLS  = 80;
    localparam int          TEXT_ROWS  = 25;
    localparam logic [7:0]  TEXT_BLANK = 8'h20;

    // Address field widths: addr = {row[4:0], col[6:0]}
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = ROW_W + COL_W;

    // Control codes
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    // Writer FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_CLR_ROW = 2'd2;
    localparam logic [1:0] ST_CLR_ALL = 2'd3;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : text_clear_seq
//  Description : Clear sweep address generator. Walks the columns of one row
//                (all_rows=0) or every row row-major from {0,0} (all_rows=1),
//                one address per cycle.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                start           - one-cycle pulse that (re)starts a sweep
//                all_rows        - sampled with start: sweep whole screen
//                row             - sampled with start: row for single sweep
//                waddr           - current sweep address {row, col}
//                active          - waddr is valid this cycle
//                done            - last address of the sweep is on waddr
//  Revision    : 1.0 - initial release
// ============================================================================
module text_clear_seq
    import text_pkg::*;
#(
    parameter int COLS = TEXT_COLS,
    parameter int ROWS = TEXT_ROWS
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              all_rows,
    input  logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] waddr,
    output logic              active,
    output logic              done
);

    localparam logic [COL_W-1:0] c_last_col = 7'(COLS - 1);
    localparam logic [ROW_W-1:0] c_last_row = 5'(ROWS - 1);

    logic             r_active;
    logic             r_all;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic w_last_col;
    logic w_last_row;
    logic w_done;

    // Separate column and row counters, each with its own end-of-range compare
    assign w_last_col = (r_col == c_last_col);
    assign w_last_row = (r_row == c_last_row);
    assign w_done     = r_active && w_last_col && (!r_all || w_last_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_all    <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_all    <= all_rows;
            r_col    <= '0;
            r_row    <= all_rows ? '0 : row;
        end else if (r_active) begin
            if (w_last_col) begin
                r_col <= '0;
                if (w_done) begin
                    r_active <= 1'b0;
                end else begin
                    r_row <= r_row + 5'd1;
                end
            end else begin
                r_col <= r_col + 7'd1;
            end
        end
    end

    assign waddr  = pack_addr(r_row, r_col);
    assign active = r_active;
    assign done   = w_done;

endmodule
`default_nettype wire

// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_writer
//  Description : Terminal-style character writer. Accepts a byte stream,
//                writes printable codes into screen RAM at the cursor and
//                interprets CR, LF, BS and FF. Line feeds (explicit or from
//                column wrap) blank the new row; FF blanks the whole screen.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                char_valid/char_data  - character offer
//                char_ready            - character accepted this cycle
//                ram_waddr/wdata/wren  - screen RAM write port
//                cursor_col/cursor_row - current cursor position
//                busy                  - row or screen clear in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS  = TEXT_COLS,
    parameter int         ROWS  = TEXT_ROWS,
    parameter logic [7:0] BLANK = TEXT_BLANK
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wren,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    localparam logic [COL_W-1:0] c_last_col = 7'(COLS - 1);
    localparam logic [ROW_W-1:0] c_last_row = 5'(ROWS - 1);

    logic [1:0]        r_state;
    logic              r_ready_en;   // holds char_ready low until first edge out of reset
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic              r_is_bs;      // WRITE cycle is a backspace blank: no cursor advance

    logic              w_xfer;
    logic [ROW_W-1:0]  w_next_row;
    logic              w_seq_start;
    logic              w_seq_all;
    logic [ROW_W-1:0]  w_seq_row;
    logic [ADDR_W-1:0] w_seq_waddr;
    logic              w_seq_active;
    logic              w_seq_done;

    assign char_ready = r_ready_en && (r_state == ST_IDLE);
    assign w_xfer     = char_valid && char_ready;
    assign w_next_row = (r_row == c_last_row) ? '0 : (r_row + 5'd1);
    assign busy       = (r_state == ST_CLR_ROW) || (r_state == ST_CLR_ALL);

    // The sweep is launched on the same edge that moves the FSM into a
    // clear state, so busy and the sweep's active window line up exactly.
    always_comb begin
        w_seq_start = 1'b0;
        w_seq_all   = 1'b0;
        w_seq_row   = w_next_row;
        if ((r_state == ST_IDLE) && w_xfer) begin
            if (char_data == CODE_LF) begin
                w_seq_start = 1'b1;
            end else if (char_data == CODE_FF) begin
                w_seq_start = 1'b1;
                w_seq_all   = 1'b1;
            end
        end else if ((r_state == ST_WRITE) && !r_is_bs && (r_col == c_last_col)) begin
            w_seq_start = 1'b1;
        end
    end

    text_clear_seq #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_seq_start),
        .all_rows (w_seq_all),
        .row      (w_seq_row),
        .waddr    (w_seq_waddr),
        .active   (w_seq_active),
        .done     (w_seq_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ready_en <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_is_bs    <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (is_printable(char_data)) begin
                            r_state <= ST_WRITE;
                            r_waddr <= pack_addr(r_row, r_col);
                            r_wdata <= char_data;
                            r_is_bs <= 1'b0;
                        end else if (char_data == CODE_CR) begin
                            r_col <= '0;
                        end else if (char_data == CODE_LF) begin
                            r_row   <= w_next_row;
                            r_state <= ST_CLR_ROW;
                        end else if (char_data == CODE_BS) begin
                            if (r_col != '0) begin
                                r_col   <= r_col - 7'd1;
                                r_waddr <= pack_addr(r_row, r_col - 7'd1);
                                r_wdata <= BLANK;
                                r_is_bs <= 1'b1;
                                r_state <= ST_WRITE;
                            end
                        end else if (char_data == CODE_FF) begin
                            r_state <= ST_CLR_ALL;
                        end
                        // any other code is consumed with no effect
                    end
                end
                ST_WRITE: begin
                    if (r_is_bs) begin
                        r_state <= ST_IDLE;
                    end else if (r_col == c_last_col) begin
                        r_col   <= '0;
                        r_row   <= w_next_row;
                        r_state <= ST_CLR_ROW;
                    end else begin
                        r_col   <= r_col + 7'd1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLR_ROW: begin
                    if (w_seq_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLR_ALL: begin
                    if (w_seq_done) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM port: WRITE drives the latched word, clear states drive the sweep.
    // All sources are reset asynchronously, so the port is quiet in reset.
    assign ram_wren   = (r_state == ST_WRITE) || (busy && w_seq_active);
    assign ram_waddr  = busy ? w_seq_waddr : r_waddr;
    assign ram_wdata  = busy ? BLANK : r_wdata;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule
`default_nettype wire

// File: tb/tb_text_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_writer
//  Description : Self-checking bench for text_writer: directed vector table,
//                hand-written corner sequences and random traffic checked
//                against a screen-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam logic [7:0] BLK = 8'h20;
    localparam int BOUND = 5000;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0] code;
        int         row;
        int         col;
        int         nwr;
        int         lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [11:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    text_writer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    wr_t got[$];
    int  got_cyc[$];
    wr_t exp_q[$];

    // Reference model state
    int mrow = 0, mcol = 0;
    int exp_busy, exp_lat;

    // Results of the last send
    int last_lat, last_busy, last_xcyc;

    // Capture every RAM write and check it lands on the visible screen
    always @(negedge clk) begin
        if (rst_n && ram_wren) begin
            got.push_back('{ram_waddr, ram_wdata});
            got_cyc.push_back(cyc);
            n_chk++;
            if (ram_waddr[6:0] >= 7'(COLS) || ram_waddr[11:7] >= 5'(ROWS)) begin
                n_fail++;
                $display("FAIL wr_range: wrote row %0d col %0d, required row<%0d col<%0d",
                         ram_waddr[11:7], ram_waddr[6:0], ROWS, COLS);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic wr_t mk(input int r, input int c, input logic [7:0] d);
        wr_t w;
        w.addr = 12'(r * 128 + c);
        w.data = d;
        return w;
    endfunction

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // ---------------- reference model: screen-level behaviour -------------
    task automatic model_lf();
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) exp_q.push_back(mk(mrow, c, BLK));
        exp_busy += COLS;
    endtask

    // Appends expected writes to exp_q; sets expected busy and ready latency
    task automatic model_char(input logic [7:0] code);
        exp_busy = 0;
        exp_lat  = 1;
        if (printable(code)) begin
            exp_q.push_back(mk(mrow, mcol, code));
            exp_lat = 2;
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                model_lf();
            end
        end else if (code == 8'h0D) begin
            mcol = 0;
        end else if (code == 8'h0A) begin
            model_lf();
        end else if (code == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                exp_q.push_back(mk(mrow, mcol, BLK));
                exp_lat = 2;
            end
        end else if (code == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) exp_q.push_back(mk(r, c, BLK));
            exp_busy = ROWS * COLS;
            mrow = 0;
            mcol = 0;
        end
        exp_lat += exp_busy;
    endtask

    // ---------------- driver ----------------------------------------------
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_char(input logic [7:0] code);
        wait_ready();
        got.delete();
        got_cyc.delete();
        char_valid = 1'b1;
        char_data  = code;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        last_xcyc  = cyc;
        last_lat   = 0;
        last_busy  = 0;
        do begin
            @(negedge clk);
            last_lat++;
            if (busy) last_busy++;
        end while (!char_ready && last_lat < BOUND);
        #1;
    endtask

    task automatic compare_writes(input string name);
        int bad = -1;
        n_chk++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d writes, expected %0d", name, got.size(), exp_q.size());
        end else begin
            foreach (got[i]) if (bad < 0 && (got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data)) bad = i;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s[%0d]: got addr %03h data %02h, expected addr %03h data %02h",
                         name, bad, got[bad].addr, got[bad].data, exp_q[bad].addr, exp_q[bad].data);
            end
        end
    endtask

    task automatic do_char(input logic [7:0] code);
        exp_q.delete();
        model_char(code);
        send_char(code);
        compare_writes("writes");
        chk("cursor_row", 32'(cursor_row), mrow);
        chk("cursor_col", 32'(cursor_col), mcol);
        chk("ready_latency", last_lat, exp_lat);
        chk("busy_cycles", last_busy, exp_busy);
        if (printable(code) && got_cyc.size() > 0)
            chk("write_latency", got_cyc[0] - last_xcyc + 1, 1);
    endtask

    vec_t vt[11];
    int   wins;

    initial begin
        vt[0]  = '{8'h41, 0, 1,  1,  2};
        vt[1]  = '{8'h0D, 0, 0,  0,  1};
        vt[2]  = '{8'h08, 0, 0,  0,  1};
        vt[3]  = '{8'h78, 0, 1,  1,  2};
        vt[4]  = '{8'h08, 0, 0,  1,  2};
        vt[5]  = '{8'h0A, 1, 0, 80, 81};
        vt[6]  = '{8'h07, 1, 0,  0,  1};
        vt[7]  = '{8'h7E, 1, 1,  1,  2};
        vt[8]  = '{8'h1F, 1, 1,  0,  1};
        vt[9]  = '{8'h7F, 1, 1,  0,  1};
        vt[10] = '{8'h20, 1, 2,  1,  2};

        // ---- reset state, checked before any clock edge ----
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wren", ram_wren, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", char_ready, 0);
        chk("rst_cursor_row", cursor_row, 0);
        chk("rst_cursor_col", cursor_col, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", char_ready, 0);
        @(posedge clk);
        #1 chk("ready_first_edge", char_ready, 1);

        // ---- directed vector table ----
        for (int i = 0; i < 11; i++) begin
            do_char(vt[i].code);
            chk("tbl_row", 32'(cursor_row), vt[i].row);
            chk("tbl_col", 32'(cursor_col), vt[i].col);
            chk("tbl_nwr", got.size(), vt[i].nwr);
            chk("tbl_lat", last_lat, vt[i].lat);
        end

        // ---- 80 printables from {3,0}: wrap and clear of row 4 ----
        do_char(8'h0D);
        do_char(8'h0A);
        do_char(8'h0A);
        for (int i = 0; i < COLS; i++) do_char(8'($urandom_range(32, 126)));
        chk("wrap_last_addr", got.size() > 0 ? 32'(got[0].addr) : 32'hFFFF, 3 * 128 + 79);
        chk("wrap_busy", last_busy, 80);
        chk("wrap_row", 32'(cursor_row), 4);
        chk("wrap_col", 32'(cursor_col), 0);

        // ---- LF on the last row wraps to row 0 ----
        for (int i = 0; i < 20; i++) do_char(8'h0A);
        for (int i = 0; i < 10; i++) do_char(8'h61 + 8'(i));
        chk("pre_lf_row", 32'(cursor_row), 24);
        do_char(8'h0A);
        chk("lf_wrap_row", 32'(cursor_row), 0);
        chk("lf_wrap_col", 32'(cursor_col), 10);
        chk("lf_wrap_first", got.size() == 80 ? 32'(got[0].addr) : 32'hFFFF, 0);
        chk("lf_wrap_last", got.size() == 80 ? 32'(got[79].addr) : 32'hFFFF, 79);

        // ---- backspace at col 0 and col 6 ----
        do_char(8'h0D);
        for (int i = 0; i < 5; i++) do_char(8'h0A);
        do_char(8'h08);
        chk("bs_col0_writes", got.size(), 0);
        chk("bs_col0_row", 32'(cursor_row), 5);
        for (int i = 0; i < 6; i++) do_char(8'h30 + 8'(i));
        do_char(8'h08);
        chk("bs_addr", got.size() == 1 ? 32'(got[0].addr) : 32'hFFFF, 5 * 128 + 5);
        chk("bs_data", got.size() == 1 ? 32'(got[0].data) : 32'hFFFF, 32'h20);

        // ---- form feed clears the screen ----
        do_char(8'h0C);
        chk("ff_writes", got.size(), 2000);
        chk("ff_ready_low", last_lat, 2001);
        do_char(8'h42);
        chk("ff_next_addr", got.size() == 1 ? 32'(got[0].addr) : 32'hFFFF, 0);

        // ---- valid held high: one transfer per ready window ----
        exp_q.delete();
        wins = 0;
        wait_ready();
        got.delete();
        char_valid = 1'b1;
        char_data  = 8'h43;
        for (int i = 0; i < 6; i++) begin
            if (char_ready) begin
                wins++;
                model_char(8'h43);
            end
            @(posedge clk);
            @(negedge clk);
        end
        char_valid = 1'b0;
        wait_ready();
        #1;
        chk("held_windows", wins, 3);
        compare_writes("held_writes");
        chk("held_col", 32'(cursor_col), mcol);

        // ---- random traffic ----
        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 99);
            logic [7:0] code;
            if (r < 68)      code = 8'($urandom_range(32, 126));
            else if (r < 76) code = 8'h0A;
            else if (r < 83) code = 8'h0D;
            else if (r < 92) code = 8'h08;
            else if (r < 97) code = 8'h80 | 8'($urandom_range(0, 127));
            else             code = 8'h0C;
            do_char(code);
        end

        // ---- reset during a screen clear ----
        wait_ready();
        got.delete();
        char_valid = 1'b1;
        char_data  = 8'h0C;
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (500) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_wren", ram_wren, 0);
        chk("abort_row", cursor_row, 0);
        chk("abort_col", cursor_col, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", char_ready, 0);
        chk("abort_writes", got.size(), 500);
        chk("abort_last_addr", got.size() == 500 ? 32'(got[499].addr) : 32'hFFFF, 6 * 128 + 19);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        @(posedge clk);
        #1 chk("abort_ready_after", char_ready, 1);
        repeat (50) @(posedge clk);
        #1 chk("abort_no_resume", got.size(), 0);
        mrow = 0;
        mcol = 0;
        do_char(8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
